// File: rtl/matrix_operand_loader_pkg.sv
// Shared types and default sizes for the matrix operand loader.
package matrix_operand_loader_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ELEMS      = 4;
  localparam int DEF_REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_A  = 2'd1,
    ST_LOAD_B  = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_operand_loader_pack_reg.sv
// Operand register written one byte lane at a time while elements stream in.
module operand_pack_reg #(
  parameter int DATA_W = 8,
  parameter int ELEMS  = 4,
  parameter int LANE_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [LANE_W-1:0]       lane,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W*ELEMS-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (we) begin
      q[lane*DATA_W +: DATA_W] <= din;
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Fetches A then B operands from the register file, one element per cycle, and
// presents them to the multiplier on a valid/ready handshake.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ELEMS      = DEF_ELEMS,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [REG_ADDR_W-1:0]   a_base,
  input  logic [REG_ADDR_W-1:0]   b_base,
  input  logic                    flush,
  output logic                    rd_en,
  output logic [REG_ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]       rd_data,
  input  logic                    wb_write,
  input  logic [REG_ADDR_W-1:0]   wb_destreg,
  input  logic [DATA_W-1:0]       wb_data,
  output logic [DATA_W*ELEMS-1:0] op_a,
  output logic [DATA_W*ELEMS-1:0] op_b,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic                    busy,
  output logic                    start_dropped,
  output state_t                  dbg_state
);

  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  state_t                r_state, w_state_next;
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic [REG_ADDR_W-1:0] r_a_base, r_b_base, w_base;
  logic                  r_start_dropped;
  logic                  w_loading, w_accept, w_launch, w_drop, w_bypass;
  logic                  w_we_a, w_we_b;
  logic [DATA_W-1:0]     w_byte;

  // Handshake: op_valid stays high with op_a/op_b stable until a cycle where
  // op_valid & op_ready is sampled high (and flush is low); that edge is the transfer.
  assign w_loading = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign w_accept  = (r_state == ST_PRESENT) && op_ready && !flush;
  assign w_launch  = start && !flush && ((r_state == ST_IDLE) || w_accept);
  assign w_drop    = start && (r_state != ST_IDLE) && !w_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_base        <= '0;
      r_b_base        <= '0;
      r_start_dropped <= 1'b0;
    end else begin
      r_start_dropped <= w_drop;
      if (w_launch) begin
        r_a_base <= a_base;
        r_b_base <= b_base;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (flush) begin
      w_state_next = ST_IDLE;
      w_idx_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_next = ST_LOAD_A;
            w_idx_next   = '0;
          end
        end
        ST_LOAD_A: begin
          if (r_idx == LAST_IDX) begin
            w_state_next = ST_LOAD_B;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
        ST_LOAD_B: begin
          if (r_idx == LAST_IDX) begin
            w_state_next = ST_PRESENT;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
        ST_PRESENT: begin
          if (w_accept) begin
            w_state_next = start ? ST_LOAD_A : ST_IDLE;
            w_idx_next   = '0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
        end
      endcase
    end
  end

  // Register index wraps naturally in REG_ADDR_W bits.
  always_comb begin
    w_base        = (r_state == ST_LOAD_B) ? r_b_base : r_a_base;
    rd_en         = w_loading;
    rd_addr       = w_loading ? (w_base + REG_ADDR_W'(r_idx)) : '0;
    op_valid      = (r_state == ST_PRESENT);
    busy          = (r_state != ST_IDLE);
    start_dropped = r_start_dropped;
    dbg_state     = r_state;
  end

  // A write-back landing on the register being read wins over the stale file value.
  assign w_bypass = w_loading && wb_write && (wb_destreg == rd_addr);
  assign w_byte   = w_bypass ? wb_data : rd_data;
  assign w_we_a   = (r_state == ST_LOAD_A) && !flush;
  assign w_we_b   = (r_state == ST_LOAD_B) && !flush;

  operand_pack_reg #(.DATA_W(DATA_W), .ELEMS(ELEMS), .LANE_W(IDX_W)) u_pack_a (
    .clk   (clk),
    .reset (reset),
    .we    (w_we_a),
    .lane  (r_idx),
    .din   (w_byte),
    .q     (op_a)
  );

  operand_pack_reg #(.DATA_W(DATA_W), .ELEMS(ELEMS), .LANE_W(IDX_W)) u_pack_b (
    .clk   (clk),
    .reset (reset),
    .we    (w_we_b),
    .lane  (r_idx),
    .din   (w_byte),
    .q     (op_b)
  );

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader with a queue-based operand scoreboard.
module tb_matrix_operand_loader;
  import matrix_operand_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush, op_ready, wb_write;
  logic [2:0]  a_base, b_base, wb_destreg, rd_addr;
  logic [7:0]  rd_data, wb_data;
  logic        rd_en, op_valid, busy, start_dropped;
  logic [31:0] op_a, op_b;
  state_t      dbg_state;

  logic [7:0]  rf [8];
  logic [63:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  matrix_operand_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .a_base        (a_base),
    .b_base        (b_base),
    .flush         (flush),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wb_write      (wb_write),
    .wb_destreg    (wb_destreg),
    .wb_data       (wb_data),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .busy          (busy),
    .start_dropped (start_dropped),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && op_valid && op_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: got %0h expected none", {op_a, op_b});
      end else begin
        check("operands", {op_a, op_b}, exp_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {rd_en, rd_addr, op_valid, busy, start_dropped}, 64'd0);
    check({tag, "_ops"}, {op_a, op_b}, 64'd0);
  endtask

  task automatic begin_load(input logic [2:0] a, input logic [2:0] b);
    start  = 1'b1;
    a_base = a;
    b_base = b;
    tick();
    start  = 1'b0;
  endtask

  // Walks the 8 read cycles; bp = cycle carrying a write-back bypass, drop = cycle with a stray start.
  task automatic load_body(input logic [2:0] a, input logic [2:0] b,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input int bp, input int drop);
    logic [2:0] exp_addr;
    exp_q.push_back({ea, eb});
    for (int i = 0; i < 8; i++) begin
      exp_addr = (i < 4) ? 3'(int'(a) + i) : 3'(int'(b) + i - 4);
      check("rd_en", rd_en, 1);
      check("rd_addr", rd_addr, exp_addr);
      check("start_dropped", start_dropped, (drop >= 0 && i == drop + 1));
      wb_write   = (i == bp);
      wb_destreg = exp_addr;
      wb_data    = 8'hAA;
      if (i == drop) begin
        start  = 1'b1;
        a_base = 3'd5;
        b_base = 3'd5;
      end
      tick();
      start    = 1'b0;
      wb_write = 1'b0;
    end
    check("valid_at_edge8", op_valid, 1);
    check("busy_at_edge8", busy, 1);
  endtask

  task automatic accept();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("idle_after_accept", {busy, op_valid, rd_en}, 0);
    check("state_idle", dbg_state, ST_IDLE);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'(i + 1);
    reset = 1'b0; start = 1'b0; flush = 1'b0; op_ready = 1'b0;
    wb_write = 1'b0; wb_destreg = 3'd0; wb_data = 8'h00;
    a_base = 3'd0; b_base = 3'd0;
    tick();
    check_all_zero("reset");
    check("reset_state", dbg_state, ST_IDLE);
    tick();
    reset = 1'b1;
    tick();

    // Case 1: basic load
    begin_load(3'd0, 3'd4);
    load_body(3'd0, 3'd4, 32'h04030201, 32'h08070605, -1, -1);
    accept();

    // Case 2: wrapping base addresses
    begin_load(3'd6, 3'd2);
    load_body(3'd6, 3'd2, 32'h02010807, 32'h06050403, -1, -1);
    accept();

    // Case 3: write-back bypass on r1
    begin_load(3'd0, 3'd4);
    load_body(3'd0, 3'd4, 32'h0403AA01, 32'h08070605, 1, -1);
    accept();

    // Case 4: stray start mid-load, then back-pressure
    begin_load(3'd0, 3'd4);
    load_body(3'd0, 3'd4, 32'h04030201, 32'h08070605, -1, 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid_busy", {op_valid, busy}, 2'b11);
      check("stall_ops", {op_a, op_b}, {32'h04030201, 32'h08070605});
    end

    // Case 5: back-to-back start on the accepting cycle
    op_ready = 1'b1;
    start    = 1'b1;
    a_base   = 3'd2;
    b_base   = 3'd6;
    tick();
    op_ready = 1'b0;
    start    = 1'b0;
    check("b2b_state", dbg_state, ST_LOAD_A);
    load_body(3'd2, 3'd6, 32'h06050403, 32'h02010807, -1, -1);
    accept();

    // Case 6: flush at edge 3, then reset at edge 5 of a new load
    begin_load(3'd0, 3'd4);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {busy, op_valid, rd_en}, 0);
    check("flush_keeps_op_b", op_b, 32'h02010807);
    begin_load(3'd0, 3'd4);
    for (int k = 0; k < 4; k++) tick();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midload_reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("after_reset");
    begin_load(3'd0, 3'd4);
    load_body(3'd0, 3'd4, 32'h04030201, 32'h08070605, -1, -1);
    accept();

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
